glitc_debug_capture: RTL and testbench
======================================

Name: glitc_debug_capture

Overview:
Consumer end of the GLITC debug bus. Takes the registered 71-bit debug bus produced by the debug mux and captures it into an internal circular buffer. Capture is governed by pretrigger / trigger / posttrigger control. The frozen record is then read back through a simple indexed read port by the register interface. This gives an on-chip logic analyser for sites where ChipScope is unavailable.

Parameters:
WIDTH, 71, debug bus width (matches debug mux output)
DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2 samples

Ports:
clk_i  in  1  capture/readout clock (same clock as debug mux)
rst_n_i  in  1  asynchronous active-low reset
debug_i  in  WIDTH  debug bus from debug mux
arm_i  in  1  single-cycle pulse: start a new capture
abort_i  in  1  single-cycle pulse: stop capture, go IDLE
force_trig_i  in  1  unconditional trigger (honoured only in ARMED)
trig_mask_i  in  WIDTH  bits participating in pattern match
trig_value_i  in  WIDTH  required values of masked bits
pretrig_i  in  DEPTH_LOG2  samples retained before trigger, latched at arm
rd_en_i  in  1  read strobe
rd_addr_i  in  DEPTH_LOG2  logical index: 0 = oldest sample, DEPTH-1 = newest
rd_data_o  out  WIDTH  read data
rd_valid_o  out  1  rd_data_o valid
state_o  out  3  current state encoding
triggered_o  out  1  trigger accepted for current capture
done_o  out  1  capture complete, buffer frozen
trig_addr_o  out  DEPTH_LOG2  physical buffer address of trigger sample

Behaviour:
- Reset (async, rst_n_i low): state IDLE; all outputs 0; wr_ptr, counters, latched pretrig 0. Buffer contents undefined.
- debug_i is registered once (debug_q). All compare/write uses debug_q.
- Match: (trig_mask_i != 0) && (((debug_q ^ trig_value_i) & trig_mask_i) == 0). Trigger = match | force_trig_i.
- States: IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
- arm_i (any state): wr_ptr<=0, cnt<=0, pretrig latched, triggered_o<=0, done_o<=0. Next state is PRE if pretrig_i>0, else ARMED.
- abort_i (any state): IDLE, triggered_o/done_o cleared. Simultaneous arm_i and abort_i: abort wins.
- PRE, ARMED and POST write debug_q at wr_ptr every cycle. wr_ptr increments, wrapping modulo DEPTH.
- PRE: cnt++. After exactly pretrig samples have been written, go to ARMED. Triggers are ignored in PRE.
- ARMED:
  - May wrap indefinitely.
  - On trigger: trig_addr_o<=wr_ptr (the trigger sample's address), triggered_o<=1, cnt<=0.
  - Next state is POST, or DONE directly if DEPTH-1-pretrig == 0.
- POST: writes exactly DEPTH-1-pretrig further samples, then DONE. done_o rises the cycle after the last write.
- DONE: no writes; buffer frozen until the next arm_i.
- Readout:
  - Physical address = (trig_addr_o - pretrig + rd_addr_i) mod DEPTH.
  - Latency is 2 cycles: address register, then registered RAM output.
  - rd_valid_o is rd_en_i delayed 2 cycles, in any state. Data is meaningful only when done_o=1.
  - rd_data_o holds its last value when not reading.
- Reads are back-to-back capable, one per cycle.
- pretrig_i range is 0..DEPTH-1; all widths are unsigned modulo DEPTH.

Decomposition:
- Shared package glitc_debug_pkg:
  - DEBUG_WIDTH=71.
  - Capture state encodings.
  - Debug mux select width.
- One sub-module, glitc_debug_capture_ram: simple dual-port RAM (one write port, one read port) with registered read output, written for BRAM inference.

Test Plan:
- Stimulus common to scenarios 2–6: debug_i = free-running counter. Because of the input register, the sample written equals the counter value one cycle earlier.
1. Reset mid-POST (rst_n_i low 3 cycles) -> state_o=0, done_o=0, triggered_o=0, trig_addr_o=0, rd_valid_o=0 immediately. Idle with no writes afterwards.
2. pretrig_i=16, mask=all ones, value=1000, arm -> trigger on sample 1000. Then done_o. Read index 16=1000, index 0=984, index 1023=2007.
3. pretrig_i=0, mask=0, force_trig_i once in ARMED when sample=50 -> index 0=50, index 1023=1073, trig_addr_o=wr_ptr at force.
4. pretrig_i=32, value matches at sample 5 (during PRE) and again at 300 -> trigger taken at 300; index 32=300.
5. mask=0 and no force for 5000 cycles -> state_o stays 2, wr_ptr wraps, done_o=0. Then arm_i and abort_i in the same cycle -> state_o=0.
6. arm_i asserted during POST -> restart: triggered_o clears, state_o=PRE. The next capture completes with correct ordering. Back-to-back reads give rd_valid_o every cycle with 2-cycle latency.

Source files
------------

// File: rtl/glitc_debug_pkg.sv
// Shared definitions for the GLITC debug bus: bus width, mux select width
// and the capture state machine encoding.
package glitc_debug_pkg;

  localparam int DEBUG_WIDTH     = 71;
  localparam int DEBUG_SEL_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  function automatic logic is_capturing(input cap_state_e s);
    return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/glitc_debug_capture_ram.sv
// Simple dual-port capture buffer: one write port, one read port with a
// registered output that holds its value between reads.
module glitc_debug_capture_ram #(
  parameter int WIDTH = 71,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/glitc_debug_capture.sv
// On-chip logic analyser: captures the registered debug bus into a circular
// buffer around a trigger, then serves the frozen record by logical index.
module glitc_debug_capture
  import glitc_debug_pkg::*;
#(
  parameter int WIDTH      = DEBUG_WIDTH,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [WIDTH-1:0]      debug_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  force_trig_i,
  input  logic [WIDTH-1:0]      trig_mask_i,
  input  logic [WIDTH-1:0]      trig_value_i,
  input  logic [DEPTH_LOG2-1:0] pretrig_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic [2:0]            state_o,
  output logic                  triggered_o,
  output logic                  done_o,
  output logic [DEPTH_LOG2-1:0] trig_addr_o
);

  localparam logic [DEPTH_LOG2-1:0] ONE = DEPTH_LOG2'(1);

  cap_state_e            state_q;
  logic [WIDTH-1:0]      debug_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, cnt_q, pretrig_q, trig_addr_q;
  logic                  triggered_q, done_q;
  logic [DEPTH_LOG2-1:0] rd_addr_q;
  logic                  rd_en_q, rd_valid_q;

  logic                  trig_hit;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] post_len;
  logic [DEPTH_LOG2-1:0] rd_phys_d;

  // Post-trigger length DEPTH-1-pretrig is simply the bitwise complement.
  always_comb begin
    trig_hit  = ((trig_mask_i != '0) &&
                 (((debug_q ^ trig_value_i) & trig_mask_i) == '0)) || force_trig_i;
    wr_en     = is_capturing(state_q) && !arm_i && !abort_i;
    post_len  = ~pretrig_q;
    rd_phys_d = trig_addr_q - pretrig_q + rd_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      debug_q <= '0;
    end else begin
      debug_q <= debug_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pretrig_q   <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort_i) begin
      state_q     <= ST_IDLE;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (arm_i) begin
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pretrig_q   <= pretrig_i;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      state_q     <= (pretrig_i != '0) ? ST_PRE : ST_ARMED;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + ONE;
      end
      case (state_q)
        ST_PRE: begin
          cnt_q <= cnt_q + ONE;
          if (cnt_q == pretrig_q - ONE) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            trig_addr_q <= wr_ptr_q;
            triggered_q <= 1'b1;
            cnt_q       <= '0;
            if (post_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_POST;
            end
          end
        end
        ST_POST: begin
          cnt_q <= cnt_q + ONE;
          if (cnt_q == post_len - ONE) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read stage 1: translate logical index to physical address.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_i;
      rd_valid_q <= rd_en_q;
      if (rd_en_i) begin
        rd_addr_q <= rd_phys_d;
      end
    end
  end

  glitc_debug_capture_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (debug_q),
    .rd_en_i   (rd_en_q),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (rd_data_o)
  );

  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign done_o      = done_q;
  assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_glitc_debug_capture.sv
// Scoreboard bench for glitc_debug_capture: directed capture scenarios with
// a free-running counter on the debug bus and hand-computed readback values.
module tb_glitc_debug_capture;

  localparam int W  = 71;
  localparam int AW = 10;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic          clk, rst_n;
  logic [W-1:0]  debug_i, trig_mask, trig_value;
  logic          arm, abort_p, force_trig, rd_en;
  logic [AW-1:0] pretrig, rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid, triggered, done;
  logic [2:0]    state;
  logic [AW-1:0] trig_addr;

  logic [W-1:0]  ctr;
  logic          ctr_clr;
  logic          mon_ignore;
  int            cyc;
  int            total, bad;
  exp_t          sb[$];

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  glitc_debug_capture dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .debug_i      (debug_i),
    .arm_i        (arm),
    .abort_i      (abort_p),
    .force_trig_i (force_trig),
    .trig_mask_i  (trig_mask),
    .trig_value_i (trig_value),
    .pretrig_i    (pretrig),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .state_o      (state),
    .triggered_o  (triggered),
    .done_o       (done),
    .trig_addr_o  (trig_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctr_clr) ctr <= '0;
    else         ctr <= ctr + 71'd1;
  end

  assign debug_i = ctr;

  // Monitor: every valid read pops the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rd_valid && !mon_ignore) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got valid data %0d, expected no read", rd_data);
      end else begin
        e = sb.pop_front();
        if (rd_data !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL rd_data: got %0d at cycle %0d, expected %0d at cycle %0d",
                   rd_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic wait_ctr(input logic [W-1:0] v);
    int n = 0;
    while (ctr != v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (ctr != v) timeout("wait_ctr");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) timeout("wait_done");
  endtask

  task automatic clear_ctr();
    @(negedge clk);
    ctr_clr = 1'b1;
    @(negedge clk);
    ctr_clr = 1'b0;
  endtask

  task automatic do_arm(input logic [AW-1:0] p, input logic [W-1:0] m, input logic [W-1:0] v);
    arm        = 1'b1;
    pretrig    = p;
    trig_mask  = m;
    trig_value = v;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] exp);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = a;
    sb.push_back('{data: exp, cyc: cyc + 2});
  endtask

  task automatic end_reads();
    int n = 0;
    @(negedge clk);
    rd_en = 1'b0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      timeout("rd_drain");
      sb.delete();
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; ctr_clr = 1'b1; mon_ignore = 1'b0;
    arm = 1'b0; abort_p = 1'b0; force_trig = 1'b0; rd_en = 1'b0;
    trig_mask = '0; trig_value = '0; pretrig = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    ctr_clr = 1'b0;

    // 1: reset in the middle of POST
    do_arm(10'd0, '0, '0);
    repeat (5) @(negedge clk);
    force_trig = 1'b1;
    @(negedge clk);
    force_trig = 1'b0;
    check("s1_post", state, 3);
    mon_ignore = 1'b1;
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    check("s1_rv_before", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("s1_state", state, 0);
    check("s1_trig", triggered, 0);
    check("s1_done", done, 0);
    check("s1_taddr", trig_addr, 0);
    check("s1_rv", rd_valid, 0);
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("s1_idle", state, 0);
    check("s1_idle_rv", rd_valid, 0);
    mon_ignore = 1'b0;

    // 2: pattern trigger with 16 pretrigger samples
    clear_ctr();
    wait_ctr(71'd10);
    do_arm(10'd16, ALL_ONES, 71'd1000);
    check("s2_pre", state, 1);
    wait_done();
    check("s2_state", state, 4);
    check("s2_trig", triggered, 1);
    check("s2_taddr", trig_addr, 990);
    do_read(10'd16, 71'd1000);
    do_read(10'd0, 71'd984);
    do_read(10'd1023, 71'd2007);
    end_reads();

    // 3: forced trigger with no pretrigger
    clear_ctr();
    wait_ctr(71'd10);
    do_arm(10'd0, '0, '0);
    check("s3_armed", state, 2);
    wait_ctr(71'd51);
    force_trig = 1'b1;
    @(negedge clk);
    force_trig = 1'b0;
    wait_done();
    check("s3_taddr", trig_addr, 40);
    do_read(10'd0, 71'd50);
    do_read(10'd1023, 71'd1073);
    end_reads();

    // 4: match during PRE is ignored, later match taken
    clear_ctr();
    wait_ctr(71'd2);
    do_arm(10'd32, ALL_ONES, 71'd5);
    wait_ctr(71'd20);
    trig_value = 71'd300;
    wait_ctr(71'd40);
    check("s4_armed", state, 2);
    check("s4_no_trig", triggered, 0);
    wait_done();
    check("s4_taddr", trig_addr, 298);
    do_read(10'd32, 71'd300);
    do_read(10'd0, 71'd268);
    do_read(10'd1023, 71'd1291);
    end_reads();

    // 5: no trigger for a long time, then simultaneous arm and abort
    do_arm(10'd0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      repeat (1000) @(negedge clk);
      check("s5_armed", state, 2);
      check("s5_done", done, 0);
    end
    arm = 1'b1;
    abort_p = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    abort_p = 1'b0;
    check("s5_abort", state, 0);
    @(negedge clk);
    check("s5_idle", state, 0);

    // 6: re-arm during POST, then back-to-back readout
    clear_ctr();
    wait_ctr(71'd10);
    do_arm(10'd8, ALL_ONES, 71'd500);
    wait_ctr(71'd600);
    check("s6_post", state, 3);
    check("s6_trig1", triggered, 1);
    do_arm(10'd8, ALL_ONES, 71'd2000);
    check("s6_rearm_state", state, 1);
    check("s6_rearm_trig", triggered, 0);
    wait_done();
    check("s6_taddr", trig_addr, 376);
    check("s6_trig2", triggered, 1);
    for (int i = 0; i < 10; i++) begin
      do_read(AW'(i), 71'd1992 + 71'(i));
    end
    do_read(10'd1023, 71'd3015);
    end_reads();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
